// File: rtl/spi_slave.sv
// SPI slave endpoint (CPOL=0, CPHA=1) oversampled in the clk domain. It has a one-deep
// transmit buffer, a receive strobe and pulses for underrun and aborted frames.
module spi_slave #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                sclk_m_q, sclk_m_d, sclk_s_q, sclk_s_d, sclk_dly_q, sclk_dly_d;
  logic                ss_m_q, ss_m_d, ss_s_q, ss_s_d, ss_dly_q, ss_dly_d;
  logic                mosi_m_q, mosi_m_d, mosi_s_q, mosi_s_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                buf_full_q, buf_full_d;
  logic                rx_valid_q, rx_valid_d;
  logic                miso_q, miso_d;
  logic                underrun_q, underrun_d;
  logic                underrun_pend_q, underrun_pend_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;

  logic                rise, fall, ss_fall, ss_rise;
  logic                word_start, start_deferred;
  logic [DATA_W-1:0]   rx_word;

  assign rise    = sclk_s_q & ~sclk_dly_q;
  assign fall    = ~sclk_s_q & sclk_dly_q;
  assign ss_fall = ~ss_s_q & ss_dly_q;
  assign ss_rise = ss_s_q & ~ss_dly_q;

  // Next-state logic: synchronizers, frame FSM, shifters and transmit buffer
  always_comb begin
    sclk_m_d        = sclk;
    sclk_s_d        = sclk_m_q;
    sclk_dly_d      = sclk_s_q;
    ss_m_d          = ss;
    ss_s_d          = ss_m_q;
    ss_dly_d        = ss_s_q;
    mosi_m_d        = mosi;
    mosi_s_d        = mosi_m_q;
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    rx_shift_d      = rx_shift_q;
    rx_data_d       = rx_data_q;
    buf_d           = buf_q;
    buf_full_d      = buf_full_q;
    miso_d          = miso_q;
    underrun_pend_d = underrun_pend_q;
    rx_valid_d      = 1'b0;
    underrun_d      = 1'b0;
    frame_err_d     = 1'b0;
    word_start      = 1'b0;
    start_deferred  = 1'b0;
    rx_word         = {rx_shift_q[DATA_W-2:0], mosi_s_q};

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          word_start = 1'b1;
        end else begin
          state_d    = IDLE;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d         = IDLE;
          bit_cnt_d       = '0;
          miso_d          = 1'b0;
          underrun_pend_d = 1'b0;
          frame_err_d     = (bit_cnt_q != '0);
        end else if (rise) begin
          miso_d          = shift_q[DATA_W-1];
          shift_d         = {shift_q[DATA_W-2:0], 1'b0};
          underrun_d      = underrun_pend_q;
          underrun_pend_d = 1'b0;
        end else if (fall) begin
          rx_shift_d = rx_word;
          if (bit_cnt_q == CNT_LAST) begin
            bit_cnt_d      = '0;
            rx_data_d      = rx_word;
            rx_valid_d     = 1'b1;
            word_start     = 1'b1;
            start_deferred = 1'b1;
          end else begin
            bit_cnt_d      = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A start after a completed word only flags underrun once the master clocks that word,
    // so a clean frame end does not report an underrun for a word that never goes out.
    if (word_start) begin
      shift_d    = buf_full_q ? buf_q : '0;
      buf_full_d = 1'b0;
      if (!buf_full_q && start_deferred) begin
        underrun_pend_d = 1'b1;
      end else begin
        underrun_d      = ~buf_full_q;
      end
    end else begin
      buf_full_d = buf_full_q;
    end

    if (tx_load && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end else begin
      buf_d      = buf_q;
    end

    busy_d = (state_d == ACTIVE);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_m_q        <= 1'b0;
      sclk_s_q        <= 1'b0;
      sclk_dly_q      <= 1'b0;
      ss_m_q          <= 1'b0;
      ss_s_q          <= 1'b0;
      ss_dly_q        <= 1'b0;
      mosi_m_q        <= 1'b0;
      mosi_s_q        <= 1'b0;
      state_q         <= IDLE;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      rx_shift_q      <= '0;
      rx_data_q       <= '0;
      buf_q           <= '0;
      buf_full_q      <= 1'b0;
      miso_q          <= 1'b0;
      underrun_pend_q <= 1'b0;
      rx_valid_q      <= 1'b0;
      underrun_q      <= 1'b0;
      frame_err_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      sclk_m_q        <= sclk_m_d;
      sclk_s_q        <= sclk_s_d;
      sclk_dly_q      <= sclk_dly_d;
      ss_m_q          <= ss_m_d;
      ss_s_q          <= ss_s_d;
      ss_dly_q        <= ss_dly_d;
      mosi_m_q        <= mosi_m_d;
      mosi_s_q        <= mosi_s_d;
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      rx_shift_q      <= rx_shift_d;
      rx_data_q       <= rx_data_d;
      buf_q           <= buf_d;
      buf_full_q      <= buf_full_d;
      miso_q          <= miso_d;
      underrun_pend_q <= underrun_pend_d;
      rx_valid_q      <= rx_valid_d;
      underrun_q      <= underrun_d;
      frame_err_q     <= frame_err_d;
      busy_q          <= busy_d;
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave endpoint that sits on the device side of the serial link driven by the team's SPI master. It runs in the system `clk` domain and oversamples `sclk`, `ss` and `mosi` through 2-flop synchronizers. It exchanges 8-bit words MSB first: `miso` is driven on `sclk` rising edges and `mosi` is sampled on `sclk` falling edges (CPOL=0, CPHA=1). It offers a one-deep transmit buffer with a load handshake, a receive strobe, and error pulses for underrun and aborted frames.

## Interface

- `DATA_W`, default 8: word width. Tests cover 8 only.
- `clk` input 1: system clock. Single clock domain; the SPI pins are asynchronous to it.
- `rst` input 1: synchronous, active-high reset.
- `sclk` input 1: serial clock from the master. Idles low.
- `ss` input 1: slave select, active low.
- `mosi` input 1: master-out serial data.
- `miso` output 1: slave-out serial data. Driven 0 whenever `ss` is high.
- `tx_data` input DATA_W: word for the next transmission.
- `tx_load` input 1: one-cycle request to capture `tx_data` into the transmit buffer.
- `tx_ready` output 1: transmit buffer is empty and can accept `tx_load`.
- `rx_data` output DATA_W: last complete received word. Held until the next word completes.
- `rx_valid` output 1: one-cycle strobe, `rx_data` updated.
- `tx_underrun` output 1: one-cycle pulse, a word started with the transmit buffer empty.
- `frame_err` output 1: one-cycle pulse, `ss` deasserted mid-word.
- `busy` output 1: frame in progress, i.e. synchronized `ss` is low.

## Operation

- **Synchronizers:** `sclk`, `ss` and `mosi` each pass through 2 flops, giving `sclk_s`, `ss_s` and `mosi_s`. `sclk_s` and `ss_s` are delayed one more flop for edge detection.
  - `rise` = `sclk_s` & !`sclk_d`.
  - `fall` = !`sclk_s` & `sclk_d`.
  - `ss_fall` and `ss_rise` are formed the same way.
- **States:**
  - IDLE (`ss_s` high). IDLE→ACTIVE on `ss_fall`.
  - ACTIVE (`ss_s` low). ACTIVE→IDLE on `ss_rise`.
  - In IDLE, `sclk` edges are ignored.
- **Transmit buffer:**
  - `tx_load` with `tx_ready`=1 captures `tx_data` and clears `tx_ready` on the next edge.
  - `tx_load` with `tx_ready`=0 is ignored; the buffer is unchanged.
- **Word start:** occurs at `ss_fall` and after every completed word while ACTIVE.
  - The shift register loads from the buffer and `tx_ready` returns to 1.
  - If the buffer is empty, load 0x00 and pulse `tx_underrun`.
  - A `tx_load` in the same cycle as a word start with an empty buffer is captured into the buffer for the next word, not the current one.
- **`rise` in ACTIVE:** `miso` <= shift[MSB]; shift <<= 1.
- **`fall` in ACTIVE:** rx_shift <= {rx_shift[DATA_W-2:0], `mosi_s`}; bit_cnt += 1.
- **Word completion:** when bit_cnt wraps from DATA_W-1 to 0:
  - `rx_data` <= the completed word; `rx_valid` pulses for 1 cycle.
  - A new word starts (back-to-back bytes within one `ss`).
- **Abort:** `ss_rise` with bit_cnt ≠ 0:
  - Pulse `frame_err`; discard the partial rx bits; no `rx_valid`.
  - The word already in the shift register is lost; the buffer is untouched.
- **Clean end:** `ss_rise` with bit_cnt = 0 produces no error.
- **Leaving ACTIVE:** bit_cnt <= 0 and `miso` <= 0.
- **Simultaneous events:** `ss_rise` has priority over `rise`/`fall` in the same cycle; that edge is ignored.

## Timing

- **Reset values:** `miso`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `tx_underrun`=0, `frame_err`=0, `busy`=0. Internal state is bit_cnt=0, buffer empty, state IDLE.
- **Reset mid-frame:** returns to IDLE immediately. The block then waits for a fresh `ss_fall`, even if `ss` is still low; there is no `rx_valid`.
- **Input latency:** a pin edge sampled at clk edge k acts on registers at edge k+2.
  - `rx_valid` is high for the cycle following edge k+2, where k is the sampling edge of the last falling `sclk`.
  - `miso` changes at edge k+2 after an `sclk` rise sampled at k.
- **Pin constraint:** `sclk` high and low phases must each be at least 4 `clk` periods, so that `miso` settles before the master samples it.
- **Master setup:** `ss` must fall at least 3 `clk` periods before the first `sclk` rise.
- **Handshake:** `tx_ready` drops 1 cycle after an accepted `tx_load`. It rises 1 cycle after a word start consumes the buffer.

## Test plan

- **Single word:** preload 0xA5, master sends 0x3C in one `ss` frame.
  - `miso` bits are 1,0,1,0,0,1,0,1.
  - `rx_data`=0x3C with a single `rx_valid` pulse.
  - `tx_ready` goes 0→1 at `ss_fall`.
- **Back-to-back words:** preload 0x11, then load 0x22 after `tx_ready`; master sends 0xF0, 0x0F in one frame.
  - Master receives 0x11, 0x22.
  - Two `rx_valid` pulses with 0xF0 then 0x0F.
  - No `tx_underrun`.
- **Underrun:** no preload; master sends 0x55.
  - `tx_underrun` pulses once at `ss_fall`.
  - Master receives 0x00; `rx_data`=0x55.
- **Abort:** `ss` rises after 5 bits.
  - `frame_err` pulses once; no `rx_valid`; `rx_data` keeps its previous value.
  - The next full frame receives correctly.
- **Ignored load and reset:**
  - `tx_load` of 0x77 while the buffer holds 0x66 leaves the buffer at 0x66.
  - Asserting `rst` mid-frame returns all outputs to reset values; no `rx_valid` until a new `ss` frame.
- **Simultaneous events:** the `ss` rising edge coincides in the same `clk` cycle with the 8th `sclk` falling edge.
  - The `fall` is ignored; `frame_err` pulses; no `rx_valid`.
